// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM arbiter.
// State encoding is fixed so the FSM value is stable across tools and probes.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic arb_state_e own_state(input logic mst);
    return (mst == M1) ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way round-robin picker with an optional owner override.
// A requesting owner always wins; otherwise a tie goes to the master that was not granted last.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  input  logic       owner_valid_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (owner_valid_i && req_i[owner_i]) begin
      gnt_o[owner_i] = 1'b1;
    end else begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = (last_gnt_i == M0) ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one sync-read RAM between the CPU datapath (m0) and the loader/DMA port (m1).
// Round-robin arbitration with a bounded lock; read data returns one cycle after the grant.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 16,
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic [AW-1:0] ram_raddr,
  output logic [AW-1:0] ram_waddr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam int unsigned      CntW   = $clog2(MAX_LOCK + 1);
  localparam logic [CntW-1:0]  MaxCnt = CntW'(MAX_LOCK);

  arb_state_e      state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic [CntW-1:0] lock_cnt_q, lock_cnt_d;
  logic [1:0]      rvalid_q, rvalid_d;

  logic [1:0]      pick_gnt;
  logic [1:0]      gnt;
  logic            gnt_idx;
  logic            gnt_lock;
  logic            other_req;
  logic [CntW-1:0] cnt_base;
  logic [CntW-1:0] cnt_inc;

  ram_arb_pick u_pick (
    .req_i         ({m1_req, m0_req}),
    .last_gnt_i    (last_gnt_q),
    .owner_valid_i (state_q != StIdle),
    .owner_i       (state_q == StOwn1),
    .gnt_o         (pick_gnt)
  );

  // No access may be accepted while reset is asserted, even combinationally.
  assign gnt    = rst_n ? pick_gnt : 2'b00;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  always_comb begin
    gnt_idx   = gnt[1];
    gnt_lock  = gnt_idx ? m1_lock : m0_lock;
    other_req = gnt_idx ? m0_req : m1_req;
    // A grant to a master that is not the current owner starts a fresh count.
    cnt_base  = (state_q == own_state(gnt_idx)) ? lock_cnt_q : '0;
    cnt_inc   = (cnt_base >= MaxCnt) ? MaxCnt : cnt_base + 1'b1;

    state_d    = StIdle;
    lock_cnt_d = '0;
    last_gnt_d = last_gnt_q;
    rvalid_d   = {gnt[1] & ~m1_we, gnt[0] & ~m0_we};

    if (gnt != 2'b00) begin
      last_gnt_d = gnt_idx;
      if (gnt_lock) begin
        if (!other_req) begin
          state_d = own_state(gnt_idx);
        end else if (cnt_inc < MaxCnt) begin
          state_d    = own_state(gnt_idx);
          lock_cnt_d = cnt_inc;
        end
        // Otherwise the limit is hit: this grant stands, ownership is released.
      end
    end
  end

  always_comb begin
    if (gnt[1]) begin
      ram_raddr = m1_addr;
      ram_waddr = m1_addr;
      ram_din   = m1_wdata;
      ram_we    = m1_we;
    end else begin
      ram_raddr = m0_addr;
      ram_waddr = m0_addr;
      ram_din   = m0_wdata;
      ram_we    = gnt[0] & m0_we;
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = ram_dout;
  assign m1_rdata  = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      last_gnt_q <= M1;
      lock_cnt_q <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
    end
  end

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_we_needs_gnt : assert property (@(posedge clk) disable iff (!rst_n) ram_we |-> (gnt != 2'b00));
  a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n) lock_cnt_q < MaxCnt);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: expected grants are hand-computed per cycle and expected
// read responses are queued at issue time, then popped by an independent rvalid monitor.
module tb_ram_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_lock, m0_we, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_lock, m1_we, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          ram_we;

  logic [DW-1:0] ram     [0:31];
  logic [DW-1:0] exp_mem [0:31];

  typedef struct packed {
    logic          mst;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  ram_arbiter #(.DW(DW), .AW(AW), .MAX_LOCK(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_lock   (m0_lock),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_lock   (m1_lock),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_raddr (ram_raddr),
    .ram_waddr (ram_waddr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  always #5 clk = ~clk;

  // Sync-read RAM with one-cycle latency.
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr[4:0]] <= ram_din;
    ram_dout <= ram[ram_raddr[4:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One bus cycle: check grant mid-cycle, record expected effects, advance past the edge.
  task automatic cyc(input string name, input logic [1:0] exp_gnt);
    @(negedge clk);
    chk(name, {30'd0, m1_gnt, m0_gnt}, {30'd0, exp_gnt});
    if (exp_gnt == 2'b00) begin
      chk({name, "_we"}, {31'd0, ram_we}, 32'd0);
    end else if (exp_gnt[1]) begin
      chk({name, "_we"}, {31'd0, ram_we}, {31'd0, m1_we});
      chk({name, "_addr"}, {16'd0, ram_waddr}, {16'd0, m1_addr});
      if (m1_we) exp_mem[m1_addr[4:0]] = m1_wdata;
      else sb.push_back(rsp_t'{mst: 1'b1, data: exp_mem[m1_addr[4:0]]});
    end else begin
      chk({name, "_we"}, {31'd0, ram_we}, {31'd0, m0_we});
      chk({name, "_addr"}, {16'd0, ram_waddr}, {16'd0, m0_addr});
      if (m0_we) exp_mem[m0_addr[4:0]] = m0_wdata;
      else sb.push_back(rsp_t'{mst: 1'b0, data: exp_mem[m0_addr[4:0]]});
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor: every rvalid must match the oldest outstanding read.
  always @(negedge clk) begin
    rsp_t e;
    if (m0_rvalid || m1_rvalid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rvalid_unexpected: got rvalid=%b%b expected none", m1_rvalid, m0_rvalid);
      end else begin
        e = sb.pop_front();
        chk("rvalid_mst", {30'd0, m1_rvalid, m0_rvalid}, e.mst ? 32'd2 : 32'd1);
        chk("rdata", {16'd0, (e.mst ? m1_rdata : m0_rdata)}, {16'd0, e.data});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    {m0_req, m0_lock, m0_we, m1_req, m1_lock, m1_we} = '0;
    m0_addr = '0; m0_wdata = '0; m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    rst_n = 1'b1;

    // Single master: m1 writes then reads back five words.
    m1_req = 1'b1;
    m1_we  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m1_addr  = AW'(i);
      m1_wdata = 16'hff00 + DW'(i);
      cyc("single_wr", 2'b10);
    end
    m1_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      m1_addr = AW'(i);
      cyc("single_rd", 2'b10);
    end

    // Idle with write enables high but no requests.
    m1_req = 1'b0;
    m0_we  = 1'b1;
    m1_we  = 1'b1;
    repeat (2) cyc("idle", 2'b00);

    // Contention without lock; last grant was m1, so m0 goes first.
    m0_we  = 1'b0;
    m1_we  = 1'b0;
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      m0_addr = AW'(k % 5);
      m1_addr = AW'(4 - (k % 5));
      cyc("contend", (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // Lock burst: m0 alone first so m1 wins the next tie, then 20 locked m1 grants.
    m1_req  = 1'b0;
    m0_addr = 16'd2;
    cyc("lk_pre", 2'b01);
    m1_req  = 1'b1;
    m1_lock = 1'b1;
    m1_addr = 16'd3;
    for (int k = 0; k < 22; k++) begin
      cyc("lk_burst", (k == 8 || k == 17) ? 2'b01 : 2'b10);
    end
    m1_req  = 1'b0;
    m1_lock = 1'b0;
    cyc("lk_drop", 2'b01);

    // Lock release: m0 owns for three grants, then drops req.
    m0_req  = 1'b0;
    m1_req  = 1'b1;
    m1_addr = 16'd1;
    cyc("rel_m1_only", 2'b10);
    m0_req  = 1'b1;
    m0_lock = 1'b1;
    m0_addr = 16'd3;
    repeat (3) cyc("rel_own0", 2'b01);
    m0_req  = 1'b0;
    m0_lock = 1'b0;
    cyc("rel_m1_next", 2'b10);

    // Reset with an m0 read in flight.
    m1_req  = 1'b0;
    m0_req  = 1'b1;
    m0_addr = 16'd1;
    cyc("rst_pre_rd", 2'b01);
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid_drop", {31'd0, m0_rvalid}, 32'd0);
    sb.delete();
    m1_req = 1'b1;
    m0_we  = 1'b1;
    m1_we  = 1'b1;
    cyc("rst_hold", 2'b00);
    rst_n   = 1'b1;
    m0_we   = 1'b0;
    m1_we   = 1'b0;
    m0_addr = 16'd0;
    m1_addr = 16'd1;
    cyc("rst_tie", 2'b01);
    cyc("rst_rr", 2'b10);

    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (2) cyc("drain", 2'b00);
    chk("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
